// File: rtl/avg_ctrl.sv
// Sequencing controller for the 4-sample averager: clear, accumulate, latch and write each result.
// Optional ACCUM idle timeout is built only when AVG_CTRL_TIMEOUT_EN is defined.
module avg_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_avg,
  input  logic              data_valid,
  output logic              data_ack,
  output logic              add_zero,
  output logic              zero_sel,
  output logic              reg_out,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [1:0]        cnt_r;
  logic [ADDR_W-1:0] remaining_r;
  logic [ADDR_W-1:0] addr_r;
  logic              last_s;
  logic              tmo_s;

  assign last_s = (remaining_r == ADDR_W'(1));

`ifdef AVG_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt_r;
  logic          err_r;

  assign tmo_s = (state_r == S_ACCUM) && !data_valid && (idle_cnt_r == TW'(TIMEOUT - 1));
  assign err   = err_r;

  // Consecutive stall counter in ACCUM; any ack or leaving ACCUM restarts it
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      err_r <= tmo_s;
      if (state_r != S_ACCUM || data_valid || tmo_s) begin
        idle_cnt_r <= '0;
      end else begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end
    end
  end
`else
  assign tmo_s = 1'b0;
  assign err   = 1'b0;
`endif

  // Next-state logic; abort and timeout override everything outside IDLE
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = (num_avg != '0) ? S_CLEAR : S_DONE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: state_nxt_s = S_ACCUM;
      S_ACCUM: begin
        if (data_valid && cnt_r == 2'd3) begin
          state_nxt_s = S_LATCH;
        end else begin
          state_nxt_s = S_ACCUM;
        end
      end
      S_LATCH: state_nxt_s = S_WRITE;
      S_WRITE: state_nxt_s = last_s ? S_DONE : S_ACCUM;
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
    if (state_r != S_IDLE && (abort || tmo_s)) begin
      state_nxt_s = S_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State, sample count, result count and write address
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= 2'd0;
      remaining_r <= '0;
      addr_r      <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (start && num_avg != '0) begin
            remaining_r <= num_avg;
            addr_r      <= '0;
          end
        end
        S_CLEAR: cnt_r <= 2'd0;
        S_ACCUM: begin
          if (data_valid) begin
            cnt_r <= cnt_r + 2'd1;
          end
        end
        S_WRITE: begin
          // An aborted write never happened, so the address must not advance
          if (!abort) begin
            addr_r      <= addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - ADDR_W'(1);
            cnt_r       <= 2'd0;
          end
        end
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  assign busy     = (state_r != S_IDLE);
  assign data_ack = (state_r == S_ACCUM) && data_valid;
  assign add_zero = !data_ack;
  assign zero_sel = (state_r == S_CLEAR) || (state_r == S_WRITE && !last_s);
  assign reg_out  = (state_r == S_LATCH) && !abort;
  assign ram_wr   = (state_r == S_WRITE) && !abort;
  assign done     = (state_r == S_DONE) && !abort;
  assign ram_addr = addr_r;

endmodule

// File: tb/tb_avg_ctrl.sv
// Bench for avg_ctrl: a cycle timeline is derived from the run rules and compared cycle by cycle,
// with a table of directed scenarios, randomized runs, a mid-run reset and a maximum-length run.
module tb_avg_ctrl;
  localparam int AW = 11;
  localparam logic [7:0] IDLE_CTRL = 8'b0100_0000;

  logic          clk_2 = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          data_valid = 1'b0;
  logic [AW-1:0] num_avg = '0;
  logic          data_ack, add_zero, zero_sel, reg_out, ram_wr, busy, done, err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    data_bus = 8'd0;
  logic [7:0]    ram_data = 8'd0;
  logic [9:0]    acc = 10'd0;

  always #5 clk_2 = ~clk_2;

  avg_ctrl dut (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .abort(abort), .num_avg(num_avg),
    .data_valid(data_valid), .data_ack(data_ack), .add_zero(add_zero), .zero_sel(zero_sel),
    .reg_out(reg_out), .ram_wr(ram_wr), .ram_addr(ram_addr), .busy(busy), .done(done), .err(err)
  );

  // Stand-in for the averager datapath, steered only by the controller outputs
  always @(posedge clk_2) begin
    if (zero_sel) acc <= 10'd0;
    else acc <= acc + (add_zero ? 10'd0 : {2'b00, data_bus});
    if (reg_out) ram_data <= acc[9:2];
  end

  typedef struct {
    logic          valid, start, abort, accum;
    logic [7:0]    data;
    logic [7:0]    ctrl;  // {ack, add_zero, zero_sel, reg_out, ram_wr, busy, done, err}
    logic [AW-1:0] addr;
    logic [7:0]    rdata;
  } cyc_t;

  typedef struct {
    int num; int b0, b1, b2, b3; int stall_idx, stall_len, abort_at;
    int exp_nwr, exp_first_wr, exp_first_rd, exp_done, exp_addr;
  } vec_t;

  cyc_t          sched [16384];
  int            ncyc;
  int            n_checks = 0;
  int            n_fail = 0;
  logic [AW-1:0] last_addr = '0;
  int            nwr, first_wr, first_rd, done_cyc, end_addr;

  task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  function automatic logic [7:0] mk(input logic ack, addz, zs, ro, wr, bsy, dn);
    return {ack, addz, zs, ro, wr, bsy, dn, 1'b0};
  endfunction

  task automatic push(input logic v, input int d, input logic accum, input logic [7:0] ctrl,
                      input logic [AW-1:0] a, input int rd);
    sched[ncyc].valid = v;
    sched[ncyc].data  = v ? d[7:0] : 8'($urandom);
    sched[ncyc].accum = accum;
    sched[ncyc].ctrl  = ctrl;
    sched[ncyc].addr  = a;
    sched[ncyc].rdata = rd[7:0];
    sched[ncyc].start = 1'b0;
    sched[ncyc].abort = 1'b0;
    ncyc++;
  endtask

  // Timeline: start cycle, CLEAR, per result (stalls+4 ACCUM, LATCH, WRITE), DONE, trailing IDLE
  task automatic build(input int num, input int bytes[$], input int stalls[$], input int abort_at, input bit noise);
    int a, sum, bi;
    ncyc = 0;
    bi   = 0;
    a    = int'(last_addr);
    push(1'b0, 0, 1'b0, IDLE_CTRL, last_addr, 0);
    sched[0].start = 1'b1;
    sched[0].abort = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (num == 0) begin
      push(1'b0, 0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1), AW'(a), 0);
    end else begin
      a = 0;
      push(1'b0, 0, 1'b0, mk(0, 1, 1, 0, 0, 1, 0), AW'(a), 0);
      for (int k = 0; k < num; k++) begin
        sum = 0;
        for (int j = 0; j < 4; j++) begin
          for (int s = 0; s < stalls[bi]; s++) push(1'b0, 0, 1'b1, mk(0, 1, 0, 0, 0, 1, 0), AW'(a), 0);
          push(1'b1, bytes[bi], 1'b1, mk(1, 0, 0, 0, 0, 1, 0), AW'(a), 0);
          sum += bytes[bi];
          bi++;
        end
        push(1'b0, 0, 1'b0, mk(0, 1, 0, 1, 0, 1, 0), AW'(a), 0);
        push(1'b0, 0, 1'b0, mk(0, 1, (k != num - 1), 0, 1, 1, 0), AW'(a), sum / 4);
        a++;
      end
      push(1'b0, 0, 1'b0, mk(0, 1, 0, 0, 0, 1, 1), AW'(a), 0);
    end
    push(1'b0, 0, 1'b0, IDLE_CTRL, AW'(a), 0);
    if (abort_at >= 1 && abort_at < ncyc - 1) begin
      sched[abort_at].abort   = 1'b1;
      sched[abort_at].ctrl[4] = 1'b0;
      sched[abort_at].ctrl[3] = 1'b0;
      sched[abort_at].ctrl[1] = 1'b0;
      sched[abort_at + 1].ctrl  = IDLE_CTRL;
      sched[abort_at + 1].addr  = sched[abort_at].addr;
      sched[abort_at + 1].accum = 1'b0;
      sched[abort_at + 1].valid = 1'b0;
      sched[abort_at + 1].start = 1'b0;
      sched[abort_at + 1].abort = 1'b0;
      ncyc = abort_at + 2;
    end
    if (noise) begin
      for (int c = 0; c < ncyc; c++) begin
        if (!sched[c].accum) sched[c].valid = 1'($urandom_range(0, 1));
        if (sched[c].ctrl[2] && !sched[c].abort) sched[c].start = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic run_sched();
    nwr = 0; first_wr = -1; first_rd = 0; done_cyc = -1; end_addr = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_2);
      start      = sched[c].start;
      abort      = sched[c].abort;
      data_valid = sched[c].valid;
      data_bus   = sched[c].data;
      #1;
      check("ctrl", c, {data_ack, add_zero, zero_sel, reg_out, ram_wr, busy, done, err}, sched[c].ctrl);
      check("ram_addr", c, ram_addr, sched[c].addr);
      if (sched[c].ctrl[3]) check("ram_data", c, ram_data, sched[c].rdata);
      if (ram_wr) begin
        if (nwr == 0) begin first_wr = c; first_rd = int'(ram_data); end
        nwr++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      end_addr = int'(ram_addr);
    end
    start = 1'b0; abort = 1'b0; data_valid = 1'b0;
    last_addr = sched[ncyc - 1].addr;
  endtask

  vec_t vecs [10];

  initial begin
    int q[$], st[$], na;
    vecs[0] = '{1, 10, 20, 30, 40, -1, 0, -1, 1, 7, 25, 8, 1};
    vecs[1] = '{3, 255, 255, 255, 255, -1, 0, -1, 3, 7, 255, 20, 3};
    vecs[2] = '{1, 4, 4, 4, 4, 2, 3, -1, 1, 10, 4, 11, 1};
    vecs[3] = '{0, 0, 0, 0, 0, -1, 0, -1, 0, -1, 0, 1, 1};
    vecs[4] = '{5, 8, 8, 8, 9, -1, 0, 12, 1, 7, 8, -1, 1};
    vecs[5] = '{1, 1, 2, 3, 6, -1, 0, -1, 1, 7, 3, 8, 1};
    vecs[6] = '{2, 1, 1, 1, 2, -1, 0, -1, 2, 7, 1, 14, 2};
    vecs[7] = '{2, 50, 50, 50, 50, -1, 0, 3, 0, -1, 0, -1, 0};
    vecs[8] = '{2, 60, 61, 62, 63, -1, 0, 7, 0, -1, 0, -1, 0};
    vecs[9] = '{1, 100, 100, 100, 104, -1, 0, 8, 1, 7, 101, -1, 1};

    #3;
    check("reset_ctrl", 0, {data_ack, add_zero, zero_sel, reg_out, ram_wr, busy, done, err}, IDLE_CTRL);
    check("reset_addr", 0, ram_addr, 0);
    @(negedge clk_2); @(negedge clk_2);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      q = {}; st = {};
      for (int j = 0; j < vecs[i].num * 4; j++) begin
        case (j % 4)
          0: q.push_back(vecs[i].b0);
          1: q.push_back(vecs[i].b1);
          2: q.push_back(vecs[i].b2);
          default: q.push_back(vecs[i].b3);
        endcase
        st.push_back(j == vecs[i].stall_idx ? vecs[i].stall_len : 0);
      end
      num_avg = AW'(vecs[i].num);
      build(vecs[i].num, q, st, vecs[i].abort_at, 1'b0);
      run_sched();
      check($sformatf("v%0d_nwr", i), i, nwr, vecs[i].exp_nwr);
      check($sformatf("v%0d_first_wr", i), i, first_wr, vecs[i].exp_first_wr);
      check($sformatf("v%0d_first_rd", i), i, first_rd, vecs[i].exp_first_rd);
      check($sformatf("v%0d_done", i), i, done_cyc, vecs[i].exp_done);
      check($sformatf("v%0d_addr", i), i, end_addr, vecs[i].exp_addr);
    end

    for (int r = 0; r < 30; r++) begin
      q = {}; st = {};
      na = $urandom_range(0, 6);
      for (int j = 0; j < na * 4; j++) begin
        q.push_back($urandom_range(0, 255));
        st.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end
      num_avg = AW'(na);
      build(na, q, st, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 50) : -1, 1'b1);
      run_sched();
    end

    // Asynchronous reset in the middle of the second result
    @(negedge clk_2);
    num_avg = AW'(2); start = 1'b1; data_valid = 1'b1; data_bus = 8'd7;
    @(negedge clk_2);
    start = 1'b0;
    repeat (8) @(negedge clk_2);
    #1 check("pre_reset_addr", 9, ram_addr, 1);
    #1 reset_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", 9, {data_ack, add_zero, zero_sel, reg_out, ram_wr, busy, done, err}, IDLE_CTRL);
    check("midrun_reset_addr", 9, ram_addr, 0);
    @(negedge clk_2);
    reset_n = 1'b1; data_valid = 1'b0; last_addr = '0;

    q = {}; st = {};
    for (int j = 0; j < 2047 * 4; j++) begin
      q.push_back($urandom_range(0, 255));
      st.push_back(0);
    end
    num_avg = AW'(2047);
    build(2047, q, st, -1, 1'b1);
    run_sched();
    check("max_nwr", 0, nwr, 2047);
    check("max_done", 0, done_cyc, 12284);
    check("max_addr", 0, end_addr, 2047);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
